// File: rtl/mac_pkg.sv
// mac_pkg: shared constants, FSM state and element types for the matrix-multiply tile
package mac_pkg;
   localparam int MAC_M   = 4;
   localparam int MAC_K   = 4;
   localparam int MAC_N   = 4;
   localparam int MAC_DIW = 8;
   localparam int MAC_DWF = 2 * MAC_DIW;

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

   typedef logic [MAC_DIW-1:0] op_t;
   typedef logic [MAC_DWF-1:0] res_t;
endpackage

// File: rtl/mac_pe.sv
// mac_pe: 2-stage multiply-accumulate lane (product register, then accumulator)
// MAC_SATURATE_EN clamps the accumulator at all-ones instead of wrapping.
module mac_pe #(
   parameter int DIW = 8,
   parameter int DWF = 16
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           clr,
   input  logic           vld,
   input  logic [DIW-1:0] a,
   input  logic [DIW-1:0] b,
   output logic [DWF-1:0] acc
);
   logic [DWF-1:0] prod;
   logic           pv;
   logic [DWF:0]   sum;
   logic [DWF-1:0] nxt;

   always_comb begin
      sum = {1'b0, acc} + {1'b0, prod};
`ifdef MAC_SATURATE_EN
      nxt = sum[DWF] ? '1 : sum[DWF-1:0];
`else
      nxt = sum[DWF-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         prod <= '0;
         pv   <= 1'b0;
         acc  <= '0;
      end else begin
         prod <= DWF'(a) * DWF'(b);
         pv   <= vld;
         if (pv) acc <= nxt;
      end
   end
endmodule

// File: rtl/mac_top.sv
// mac_top: C = A x B compute tile with load/compute/done FSM and M*N pipelined MAC lanes
// Optional MAC_SATURATE_EN selects saturating accumulation in every lane.
module mac_top
   import mac_pkg::*;
#(
   parameter int param_M            = MAC_M,
   parameter int param_K            = MAC_K,
   parameter int param_N            = MAC_N,
   parameter int DATA_WIDTH_INITIAL = MAC_DIW,
   parameter int DATA_WIDTH_FINAL   = 2 * DATA_WIDTH_INITIAL
) (
   input  logic                                                      clk,
   input  logic                                                      rstn,
   input  logic                                                      host2block_val,
   output logic                                                      host2block_rdy,
   input  logic [param_M*param_K-1:0][DATA_WIDTH_INITIAL-1:0]        a_data_in_ext,
   input  logic [param_K*param_N-1:0][DATA_WIDTH_INITIAL-1:0]        b_data_in_ext,
   input  logic                                                      a_b_we_ext,
   input  logic                                                      block2host_rdy,
   input  logic                                                      c_re_ext,
   output logic [param_M*param_N*DATA_WIDTH_FINAL-1:0]               c_data_out_ext,
   output logic                                                      mac_done,
   output logic                                                      block2host_val
);
   localparam int CW = $clog2(param_K + 2);
   localparam int KW = (param_K > 1) ? $clog2(param_K) : 1;

   state_t state;
   logic [CW-1:0] cnt;
   logic [KW-1:0] kk;
   logic          load_fire;
   logic          in_vld;
   logic [param_M-1:0][param_K-1:0][DATA_WIDTH_INITIAL-1:0] a_q;
   logic [param_N-1:0][param_K-1:0][DATA_WIDTH_INITIAL-1:0] b_q;
   logic [param_M-1:0][param_N-1:0][DATA_WIDTH_FINAL-1:0]   acc;

   always_comb begin
      load_fire = (state == LOAD) && a_b_we_ext;
      in_vld    = (state == COMPUTE) && (cnt < CW'(param_K));
      kk        = in_vld ? cnt[KW-1:0] : '0;
   end

   // Accumulators clear on the capture edge so COMPUTE starts from zero.
   for (genvar m = 0; m < param_M; m++) begin : g_row
      for (genvar n = 0; n < param_N; n++) begin : g_col
         mac_pe #(.DIW(DATA_WIDTH_INITIAL), .DWF(DATA_WIDTH_FINAL)) u_pe (
            .clk  (clk),
            .rstn (rstn),
            .clr  (load_fire),
            .vld  (in_vld),
            .a    (a_q[m][kk]),
            .b    (b_q[n][kk]),
            .acc  (acc[m][n])
         );
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state          <= IDLE;
         cnt            <= '0;
         a_q            <= '0;
         b_q            <= '0;
         host2block_rdy <= 1'b0;
         mac_done       <= 1'b0;
         block2host_val <= 1'b0;
         c_data_out_ext <= '0;
      end else begin
         case (state)
            IDLE: if (host2block_val) begin
               state          <= LOAD;
               host2block_rdy <= 1'b1;
            end
            LOAD: if (a_b_we_ext) begin
               a_q            <= a_data_in_ext;
               b_q            <= b_data_in_ext;
               cnt            <= '0;
               host2block_rdy <= 1'b0;
               state          <= COMPUTE;
            end
            COMPUTE: begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(param_K + 1)) begin
                  state          <= DONE;
                  mac_done       <= 1'b1;
                  block2host_val <= 1'b1;
               end
            end
            DONE: if (c_re_ext && block2host_rdy) begin
               c_data_out_ext <= acc;
               mac_done       <= 1'b0;
               block2host_val <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_top.sv
// tb_mac_top: table vectors, hand sequences and random ops against a matrix-product model
module tb_mac_top;
   localparam int M = 4, K = 4, N = 4, DIW = 8, DWF = 16;
   localparam int CWID = M * N * DWF;

   typedef logic [M*K-1:0][DIW-1:0] a_t;
   typedef logic [K*N-1:0][DIW-1:0] b_t;
   typedef logic [CWID-1:0]         c_t;
   typedef struct {
      string nm;
      a_t    a;
      b_t    b;
      c_t    c;
   } vec_t;

   logic clk = 0, rstn = 0;
   logic host2block_val = 0, a_b_we_ext = 0, block2host_rdy = 0, c_re_ext = 0;
   logic host2block_rdy, mac_done, block2host_val;
   a_t   a_in = '0;
   b_t   b_in = '0;
   c_t   c_out;

   int nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   mac_top dut (
      .clk            (clk),
      .rstn           (rstn),
      .host2block_val (host2block_val),
      .host2block_rdy (host2block_rdy),
      .a_data_in_ext  (a_in),
      .b_data_in_ext  (b_in),
      .a_b_we_ext     (a_b_we_ext),
      .block2host_rdy (block2host_rdy),
      .c_re_ext       (c_re_ext),
      .c_data_out_ext (c_out),
      .mac_done       (mac_done),
      .block2host_val (block2host_val)
   );

   task automatic check(input string name, input c_t act, input c_t exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // C[m][n] = sum_k A[m][k]*B[k][n], reduced by wrap or clamp
   function automatic c_t model(input a_t a, input b_t bt);
      c_t c = '0;
      for (int m = 0; m < M; m++)
         for (int n = 0; n < N; n++) begin
            int s = 0;
            for (int k = 0; k < K; k++) s += int'(a[m*K+k]) * int'(bt[n*K+k]);
`ifdef MAC_SATURATE_EN
            if (s > (1 << DWF) - 1) s = (1 << DWF) - 1;
`endif
            c[(m*N+n)*DWF +: DWF] = DWF'(s % (1 << DWF));
         end
      return c;
   endfunction

   task automatic run_op(input string nm, input a_t a, input b_t b, input c_t exp,
                         input bit junk, input bit stall);
      c_t prev = c_out;
      int cyc = 0;
      host2block_val = 1;
      tick();
      host2block_val = 0;
      check({nm, " rdy"}, c_t'(host2block_rdy), c_t'(1));
      a_in = a;
      b_in = b;
      a_b_we_ext = 1;
      tick();
      a_b_we_ext = 0;
      check({nm, " rdy_drop"}, c_t'(host2block_rdy), c_t'(0));
      while (!mac_done && cyc < 50) begin
         if (junk) begin
            a_in = {4{$urandom}};
            b_in = {4{$urandom}};
            a_b_we_ext = 1;
         end
         tick();
         cyc++;
      end
      a_b_we_ext = 0;
      check({nm, " latency"}, c_t'(cyc), c_t'(K + 2));
      check({nm, " b2h_val"}, c_t'(block2host_val), c_t'(1));
      if (stall) begin
         c_re_ext = 1;
         block2host_rdy = 0;
         tick();
         check({nm, " stall_done"}, c_t'(mac_done), c_t'(1));
         check({nm, " stall_c"}, c_out, prev);
      end
      c_re_ext = 1;
      block2host_rdy = 1;
      tick();
      c_re_ext = 0;
      block2host_rdy = 0;
      check({nm, " c"}, c_out, exp);
      check({nm, " done_drop"}, c_t'({mac_done, block2host_val}), c_t'(0));
   endtask

   initial begin
      vec_t tbl[4];
      int   basic[16] = '{56, 62, 68, 74, 152, 174, 196, 218,
                          248, 286, 324, 362, 344, 398, 452, 506};
      int   ovf;
      a_t   ra;
      b_t   rb;
`ifdef MAC_SATURATE_EN
      ovf = 65535;
`else
      ovf = 63492;
`endif
      tbl[0].nm = "basic";
      for (int i = 0; i < 16; i++) begin
         tbl[0].a[i] = DIW'(i);
         tbl[0].b[(i % N) * K + i / N] = DIW'(i);
         tbl[0].c[i*DWF +: DWF] = DWF'(basic[i]);
      end
      tbl[1].nm = "overflow";
      tbl[1].a = '1;
      tbl[1].b = '1;
      tbl[2].nm = "zeros";
      tbl[2].a = '0;
      tbl[2].b = '0;
      tbl[2].c = '0;
      tbl[3].nm = "ones";
      for (int i = 0; i < 16; i++) begin
         tbl[1].c[i*DWF +: DWF] = DWF'(ovf);
         tbl[3].a[i] = 8'd1;
         tbl[3].b[i] = 8'd1;
         tbl[3].c[i*DWF +: DWF] = 16'd4;
      end

      repeat (5) tick();
      check("reset c", c_out, '0);
      check("reset rdy", c_t'(host2block_rdy), c_t'(0));
      check("reset done", c_t'(mac_done), c_t'(0));
      check("reset val", c_t'(block2host_val), c_t'(0));
      rstn = 1;
      tick();

      for (int i = 0; i < 4; i++) run_op(tbl[i].nm, tbl[i].a, tbl[i].b, tbl[i].c, 0, i == 0);

      run_op("pre_abort", tbl[0].a, tbl[0].b, tbl[0].c, 0, 0);
      host2block_val = 1;
      tick();
      host2block_val = 0;
      a_in = tbl[1].a;
      b_in = tbl[1].b;
      a_b_we_ext = 1;
      tick();
      a_b_we_ext = 0;
      tick();
      tick();
      rstn = 0;
      tick();
      rstn = 1;
      check("abort rdy", c_t'(host2block_rdy), c_t'(0));
      check("abort done", c_t'(mac_done), c_t'(0));
      check("abort c", c_out, '0);
      repeat (K + 4) tick();
      check("abort no_done", c_t'({mac_done, block2host_val}), c_t'(0));

      run_op("basic2", tbl[0].a, tbl[0].b, tbl[0].c, 0, 0);
      a_in = tbl[1].a;
      b_in = tbl[1].b;
      a_b_we_ext = 1;
      c_re_ext = 1;
      block2host_rdy = 1;
      tick();
      tick();
      a_b_we_ext = 0;
      c_re_ext = 0;
      block2host_rdy = 0;
      check("idle strobes rdy", c_t'(host2block_rdy), c_t'(0));
      check("idle strobes done", c_t'(mac_done), c_t'(0));
      check("idle strobes c", c_out, tbl[0].c);
      run_op("compute_junk", tbl[0].a, tbl[0].b, tbl[0].c, 1, 0);

      for (int t = 0; t < 25; t++) begin
         ra = {4{$urandom}};
         rb = {4{$urandom}};
         if (t % 5 == 0) ra = ~(ra & {4{$urandom}});
         run_op($sformatf("rand%0d", t), ra, rb, model(ra, rb), 0, $urandom_range(0, 1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/mac_top.md
# mac_top

Matrix-multiply accelerator computing C = A × B for M×K by K×N 8-bit unsigned matrices, producing 16-bit elements. The host loads A and B in one beat through a valid/ready handshake. The block computes all M·N dot products with an array of pipelined MAC lanes, then returns the whole C matrix in one beat through a second handshake. It is a self-contained compute tile behind a simple host port.

## Interface
Parameters:
- param_M, 4, rows of A and C
- param_K, 4, inner dimension
- param_N, 4, columns of B and C
- DATA_WIDTH_INITIAL, 8, operand width (unsigned)
- DATA_WIDTH_FINAL, 2·DATA_WIDTH_INITIAL, result element width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  reset; one clock, reset synchronous, active-low
- host2block_val  in  1  host requests a load
- host2block_rdy  out  1  block ready to accept A/B write
- a_data_in_ext  in  [M·K][DIW]  A row-major: element [m·K+k] = A[m][k]
- b_data_in_ext  in  [K·N][DIW]  B transposed (column-major): element [n·K+k] = B[k][n]
- a_b_we_ext  in  1  write strobe for A and B
- block2host_rdy  in  1  host ready to take result
- c_re_ext  in  1  result read strobe
- c_data_out_ext  out  M·N·DWF  C row-major: bits [(m·N+n)·DWF +: DWF] = C[m][n]
- mac_done  out  1  computation complete, result pending
- block2host_val  out  1  result valid

## Operation
- Four-state FSM: IDLE, LOAD, COMPUTE, DONE.
- IDLE → LOAD when host2block_val=1.
- LOAD: host2block_rdy=1. On a_b_we_ext=1, capture a_data_in_ext and b_data_in_ext into internal register arrays and go to COMPUTE. Without a_b_we_ext, stay in LOAD.
- COMPUTE: M·N lanes, one per C element. Each lane is fed A[m][k] and Bt[n][k] for k=0..K-1, one k per cycle. Accumulators clear at COMPUTE entry.
- Arithmetic: 8×8 unsigned product is 16 bits. Accumulation is DWF bits and wraps modulo 2^DWF.
- COMPUTE → DONE after the last product drains out of the pipeline.
- DONE: mac_done=1 and block2host_val=1.
  - A read is accepted when c_re_ext=1 and block2host_rdy=1 in the same cycle. On acceptance, C is registered into c_data_out_ext and the FSM returns to IDLE.
  - c_re_ext without block2host_rdy is ignored.
- c_data_out_ext holds its value until the next accepted read.
- a_b_we_ext outside LOAD and c_re_ext outside DONE are ignored.
- Reset values: state IDLE; all outputs 0, including c_data_out_ext; A/B arrays and accumulators 0.
- Reset mid-operation aborts the operation and discards any pending result.

## Timing
- host2block_rdy asserts the cycle after host2block_val is sampled in IDLE.
- Operand capture happens on the edge where LOAD and a_b_we_ext are both true.
- MAC lane pipeline has 2 stages: multiply register, then accumulate register.
- COMPUTE lasts K+2 cycles (6 at defaults). mac_done rises on the following edge.
- mac_done and block2host_val stay high until the read-accept edge and drop on that edge. c_data_out_ext is valid immediately after that edge.
- Total latency, write edge to mac_done high: K+2 cycles.

## Configuration
- MAC_SATURATE_EN defined: each accumulator clamps at 2^DWF−1 (16'hFFFF) instead of wrapping.
- Undefined (default): modulo-2^DWF wrap.

## Structure
- Package mac_pkg holds:
  - default parameter constants;
  - the FSM state enum typedef (IDLE/LOAD/COMPUTE/DONE);
  - operand and result element typedefs.
- Sub-module mac_pe: one 2-stage pipelined multiply-accumulate lane with clear, valid-in and saturate option. mac_top instantiates M·N copies via generate, plus the FSM and operand/result registers.

## Test plan
- Reset: hold rstn=0 for 5 cycles → all outputs 0, host2block_rdy=0, mac_done=0.
- Basic multiply: A[i]=i, B[i]=i (row-major, B sent transposed) → C row 0 = 56,62,68,74; row 1 = 152,174,196,218; row 2 = 248,286,324,362; row 3 = 344,398,452,506. mac_done rises 6 cycles after the write edge.
- Read handshake:
  - c_re_ext=1 with block2host_rdy=0 in DONE → no transfer; stays DONE.
  - Then both =1 → output updates, FSM returns to IDLE, mac_done=0.
- Overflow: all A,B = 255 → each C element = 4·65025 mod 65536 = 63492; with MAC_SATURATE_EN → 65535.
- Reset mid-COMPUTE: pulse rstn low for 1 cycle → IDLE, mac_done stays 0, c_data_out_ext=0.
- Ignored strobes: a_b_we_ext in IDLE, or new data during COMPUTE → no effect; the basic-multiply result stays unchanged.
